uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud ticks per bit period; must be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clk_baud  input  1  oversample tick enable, one clk_in cycle wide, OVERSAMPLE ticks per bit.
REQ-006 rx_in  input  1  asynchronous serial line; idles high.
REQ-007 rx_ack  input  1  consumer acknowledge for the held byte.
REQ-008 data_in  output  DATA_BITS  last correctly framed byte.
REQ-009 rx_valid  output  1  data_in holds an unacknowledged byte.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 framing_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun_err  output  1  one-cycle pulse: new byte overwrote an unacknowledged byte.
REQ-013 parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-014 rx_in shall pass through a 2-flop synchronizer; all logic shall use only the synchronized value rxs.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; the tick counter and bit index advance only on cycles with clk_baud=1.
REQ-016 IDLE: a high-to-low transition of rxs shall enter START with tick count 0.
REQ-017 START: at tick count OVERSAMPLE/2-1 (mid-bit), rxs=1 shall return to IDLE as a false start with no flag; rxs=0 shall enter DATA with count 0 and index 0.
REQ-018 DATA: at tick count OVERSAMPLE-1, rxs shall shift into bit DATA_BITS-1 of the shift register (right shift); after index DATA_BITS-1 the FSM shall go to PARITY if enabled, else STOP.
REQ-019 STOP: at tick count OVERSAMPLE-1, the FSM shall sample rxs and enter IDLE on the next cycle.
REQ-020 Stop sampled 1: data_in shall load the shift register and rx_valid shall rise on the next cycle (latency: 1 clk_in after stop mid-bit sample).
REQ-021 Stop sampled 0: framing_err shall pulse, and data_in and rx_valid shall remain unchanged.
REQ-022 rx_valid shall stay high until a cycle with rx_ack=1 and then clear; rx_ack with rx_valid=0 shall be ignored.
REQ-023 Completion while rx_valid=1 and rx_ack=0: overrun_err shall pulse, data_in shall take the new byte, and rx_valid shall stay 1.
REQ-024 Completion in the same cycle as rx_ack: no overrun, and rx_valid shall stay 1 with the new byte.
REQ-025 A frame with a parity error shall still load data_in (parity_err and rx_valid together).
REQ-026 clk_baud held low shall freeze the FSM and counters indefinitely.

Reset
REQ-027 rst shall force IDLE, counters and shift register 0, data_in 0, rx_valid 0, all error pulses 0, busy 0, synchronizer flops 1.
REQ-028 rst asserted mid-frame shall abort the frame with no flags; reception shall resume at the next falling edge after release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state, one bit period long, sampled at OVERSAMPLE-1; even parity checked; mismatch pulses parity_err in the completion cycle.
REQ-030 Macro UART_RX_PARITY_EN undefined: PARITY state unreachable/absent, DATA goes directly to STOP, parity_err tied 0.

Structure
REQ-031 Package uart_pkg shall hold the rx state enum and the shared OVERSAMPLE and DATA_BITS default constants.
REQ-032 Sub-module uart_rx_sync shall implement the 2-flop synchronizer and falling-edge detect.

Verification
REQ-033 Frame 0xA5 (OVERSAMPLE=16, tick every 4 clk_in) -> data_in=0xA5, rx_valid=1, no error pulses.
REQ-034 rx_in low for 5 ticks, then high -> return to IDLE, rx_valid=0, no flags.
REQ-035 Frame 0x3C with stop bit 0 -> framing_err one-cycle pulse, data_in keeps its prior value 0x00.
REQ-036 Frames 0x11 then 0x22 with no rx_ack -> overrun_err pulse, data_in=0x22, rx_valid=1; then rx_ack -> rx_valid=0.
REQ-037 rst pulsed during data bit 3, then frame 0x7E -> data_in=0x7E, no errors.
REQ-038 With UART_RX_PARITY_EN, frame 0x01 with parity bit 0 -> parity_err pulse and data_in=0x01.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default constants for the UART receiver.
//               The receiver state enum and the OVERSAMPLE / DATA_BITS
//               defaults live here so the top and any sub-blocks agree.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default number of baud ticks per bit period (even, >= 4).
  localparam int unsigned UART_OVERSAMPLE = 16;
  // Default number of data bits per frame (LSB first on the line).
  localparam int unsigned UART_DATA_BITS  = 8;

  // Receiver FSM states; RX_PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line plus
//               a falling-edge detector on the synchronized value. All flops
//               reset to 1 so an idle (high) line never looks like an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rxs,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and one-cycle history of the synchronized line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rxs  = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampling UART receiver. Detects a start edge, confirms it
//               at mid-bit, samples DATA_BITS data bits (LSB first) and the
//               stop bit at mid-bit, and holds the last good byte until the
//               consumer acknowledges it. Framing and overrun errors are
//               reported as one-cycle pulses.
//               Optional even parity: define UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 clk_baud,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Tick counts at which the start bit is confirmed and other bits sampled.
  localparam logic [CNT_W-1:0] c_mid_tick  = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] c_last_tick = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_fall;

  rx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_done;
  logic                 w_load;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_oe;

  uart_rx_sync u_sync (
    .i_clk  (clk_in),
    .i_rst  (rst),
    .i_rx   (rx_in),
    .o_rxs  (w_rxs),
    .o_fall (w_fall)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par, w_par_nxt;
  logic r_pe;
  // Even parity: data ones plus the parity bit must be an even count.
  logic w_par_bad;
  assign w_par_bad = (^r_shift) ^ r_par;
`endif

  // FSM state, tick counter, bit index and shift register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Next-state logic; everything but the idle edge check waits for a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: if (clk_baud) begin
        if (r_cnt == c_mid_tick) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // Line back high at mid start bit means a glitch, not a frame.
          w_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: if (clk_baud) begin
        if (r_cnt == c_last_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          if (r_idx == c_last_idx) begin
            w_idx_nxt   = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = RX_PARITY;
`else
            w_state_nxt = RX_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (clk_baud) begin
        if (r_cnt == c_last_tick) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rxs;
          w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      RX_STOP: if (clk_baud) begin
        if (r_cnt == c_last_tick) begin
          w_cnt_nxt   = '0;
          w_done      = 1'b1;
          w_state_nxt = RX_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // A good stop bit commits the byte; a low stop bit only raises an error.
  assign w_load = w_done & w_rxs;

  // Held byte, valid handshake and one-cycle error pulses.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_oe    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe    <= 1'b0;
`endif
    end else begin
      r_fe <= w_done & ~w_rxs;
      r_oe <= w_load & r_valid & ~rx_ack;
`ifdef UART_RX_PARITY_EN
      r_pe <= w_load & w_par_bad;
`endif
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_in     = r_data;
  assign rx_valid    = r_valid;
  assign busy        = (r_state != RX_IDLE);
  assign framing_err = r_fe;
  assign overrun_err = r_oe;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_pe;
`else
  assign parity_err  = 1'b0;
`endif

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver. A table of frames is
//               sent back to back with expected held byte, valid and error
//               pulse counts; hand-written sequences cover the false start,
//               reset mid-frame and (with UART_RX_PARITY_EN) parity error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int BAUD_DIV = 4;               // clk_in cycles per baud tick
  localparam int BIT_CLK  = 16 * BAUD_DIV;   // clk_in cycles per bit

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_oe;
  } vec_t;

  logic       clk_in;
  logic       rst;
  logic       clk_baud;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] data_in;
  logic       rx_valid;
  logic       busy;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  int n_cmp;
  int n_bad;
  int tot_fe, tot_oe, tot_pe;
  int base_fe, base_oe, base_pe;
  int ph;
  vec_t vecs[7];

  uart_receiver dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_baud    (clk_baud),
    .rx_in       (rx_in),
    .rx_ack      (rx_ack),
    .data_in     (data_in),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Free-running baud tick, one clk_in cycle wide every BAUD_DIV cycles.
  initial begin
    clk_baud = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk_in);
      #1;
      ph = (ph + 1) % BAUD_DIV;
      clk_baud = (ph == 0);
    end
  end

  // Count the cycles each error output is high.
  initial begin
    tot_fe = 0; tot_oe = 0; tot_pe = 0;
    forever begin
      @(negedge clk_in);
      if (framing_err === 1'b1) tot_fe++;
      if (overrun_err === 1'b1) tot_oe++;
      if (parity_err  === 1'b1) tot_pe++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLK) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bz) rx_in = 1'b1;
`endif
    drive_bit(stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic snap;
    base_fe = tot_fe;
    base_oe = tot_oe;
    base_pe = tot_pe;
  endtask

  task automatic pulse_ack;
    @(posedge clk_in); #1;
    rx_ack = 1'b1;
    @(posedge clk_in); #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst    = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};  // framing error, data kept
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 0};  // clean frame
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};  // left unacknowledged
    vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1};  // overrun over 0x11
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1, 0};  // framing error while valid
    vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 0, 0};

    // Reset state.
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check("reset data_in", 32'(data_in), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset err pulses", {29'd0, framing_err, overrun_err, parity_err}, 32'h0);
    @(posedge clk_in); #1;
    rst = 1'b0;
    drive_bit(1'b1);

    // Table of frames.
    for (int i = 0; i < 7; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
      @(negedge clk_in);
      check($sformatf("v%0d data_in", i), 32'(data_in), 32'(vecs[i].exp_data));
      check($sformatf("v%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d framing_err", i), 32'(tot_fe - base_fe), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d overrun_err", i), 32'(tot_oe - base_oe), 32'(vecs[i].exp_oe));
      check($sformatf("v%0d parity_err", i), 32'(tot_pe - base_pe), 32'h0);
      check($sformatf("v%0d busy", i), 32'(busy), 32'h0);
      if (vecs[i].ack) begin
        pulse_ack();
        @(negedge clk_in);
        check($sformatf("v%0d ack clears valid", i), 32'(rx_valid), 32'h0);
      end
    end

    // Spurious ack while nothing is held is ignored.
    pulse_ack();
    @(negedge clk_in);
    check("idle ack valid", 32'(rx_valid), 32'h0);

    // False start: line low for about 5 ticks only.
    snap();
    rx_in = 1'b0;
    repeat (3 * BAUD_DIV) @(posedge clk_in);
    @(negedge clk_in);
    check("false start busy", 32'(busy), 32'h1);
    repeat (2 * BAUD_DIV) @(posedge clk_in);
    #1;
    rx_in = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk_in);
    check("false start idle", 32'(busy), 32'h0);
    check("false start valid", 32'(rx_valid), 32'h0);
    check("false start data", 32'(data_in), 32'h80);
    check("false start flags", 32'((tot_fe - base_fe) + (tot_oe - base_oe) + (tot_pe - base_pe)), 32'h0);

    // Reset in the middle of data bit 3 of 0x7E, then a full 0x7E frame.
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLK / 2) @(posedge clk_in);
    @(negedge clk_in);
    check("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("mid reset busy", 32'(busy), 32'h0);
    check("mid reset data_in", 32'(data_in), 32'h00);
    @(posedge clk_in); #1;
    rst = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    @(negedge clk_in);
    check("post-reset data_in", 32'(data_in), 32'h7E);
    check("post-reset rx_valid", 32'(rx_valid), 32'h1);
    check("post-reset flags", 32'((tot_fe - base_fe) + (tot_oe - base_oe) + (tot_pe - base_pe)), 32'h0);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // 0x01 with parity bit 0 breaks even parity but still loads the byte.
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    @(negedge clk_in);
    check("parity data_in", 32'(data_in), 32'h01);
    check("parity rx_valid", 32'(rx_valid), 32'h1);
    check("parity_err pulse", 32'(tot_pe - base_pe), 32'h1);
    check("parity other flags", 32'((tot_fe - base_fe) + (tot_oe - base_oe)), 32'h0);
    pulse_ack();
`else
    check("parity_err never set", 32'(tot_pe), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_receiver
`default_nettype wire
